// File: rtl/tmds_serializer_pkg.sv
// -----------------------------------------------------------------------------
// tmds_serializer_pkg
// Shared TMDS constants for the serializer and its shift lanes:
//   - TMDS_W  : width of one TMDS symbol
//   - CTRL_xx : the four TMDS control symbols (CTRL_00 is the idle filler)
//   - CLK_PAT : clock-lane symbol, LSB-first five 1s then five 0s
//   - last_slot(): index of the final bit-slot of a word period
// -----------------------------------------------------------------------------
package tmds_serializer_pkg;

    localparam int TMDS_W = 10;

    localparam logic [TMDS_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] CTRL_11 = 10'b1010101011;

    localparam logic [TMDS_W-1:0] CLK_PAT = 10'b0000011111;

    // DDR moves two bits per cycle (5 slots), SDR one bit per cycle (10 slots).
    function automatic logic [3:0] last_slot(input logic ddr);
        return ddr ? 4'd4 : 4'd9;
    endfunction

endpackage

// File: rtl/tmds_shift_lane.sv
// -----------------------------------------------------------------------------
// tmds_shift_lane
// One 10-bit TMDS shift register, LSB first. Reloads only when i_load is high,
// otherwise shifts right by 2 (DDR) or 1 (SDR) every cycle.
// Ports:
//   clk_shift    in   bit-rate clock
//   rst          in   synchronous active-high reset (loads P_RST_WORD)
//   i_load       in   reload strobe (word boundary)
//   i_load_word  in   word to load on i_load
//   o_pair       out  DDR: {later, earlier} bit pair; SDR: {1'b0, bit}
// -----------------------------------------------------------------------------
module tmds_shift_lane
    import tmds_serializer_pkg::*;
#(
    parameter logic              C_ddr      = 1'b0,
    parameter logic [TMDS_W-1:0] P_RST_WORD = CTRL_00
) (
    input  logic              clk_shift,
    input  logic              rst,
    input  logic              i_load,
    input  logic [TMDS_W-1:0] i_load_word,
    output logic [1:0]        o_pair
);

    logic [TMDS_W-1:0] r_sh;

    always_ff @(posedge clk_shift) begin
        if (rst) begin
            r_sh <= P_RST_WORD;
        end else if (i_load) begin
            r_sh <= i_load_word;
        end else begin
            r_sh <= r_sh >> (C_ddr ? 2 : 1);
        end
    end

    // Outputs come straight from the register: no input-to-output path.
    generate
        if (C_ddr) begin : g_ddr
            assign o_pair = r_sh[1:0];
        end else begin : g_sdr
            assign o_pair = {1'b0, r_sh[0]};
        end
    endgenerate

endmodule

// File: rtl/tmds_serializer.sv
// -----------------------------------------------------------------------------
// tmds_serializer
// Takes one 10-bit TMDS word per colour lane through a 1-entry holding buffer
// (valid/ready) and shifts it out LSB-first as DDR pairs or SDR bits, plus a
// generated TMDS clock lane. Everything runs on clk_shift.
// Ports:
//   clk_shift      in   bit-rate clock (only clock)
//   rst            in   synchronous active-high reset
//   in_red/green/blue in 10-bit TMDS words
//   in_valid       in   word triple valid
//   in_ready       out  holding buffer can accept this cycle
//   word_tick      out  pulse on last bit-slot of each word period
//   underflow      out  sticky: a boundary found the holding buffer empty
//   clr_underflow  in   clears underflow (a same-cycle set takes priority)
//   out_clock      out  TMDS clock lane pair
//   out_red/green/blue out data lane pairs
// -----------------------------------------------------------------------------
module tmds_serializer
    import tmds_serializer_pkg::*;
#(
    parameter logic C_ddr = 1'b0
) (
    input  logic              clk_shift,
    input  logic              rst,
    input  logic [TMDS_W-1:0] in_red,
    input  logic [TMDS_W-1:0] in_green,
    input  logic [TMDS_W-1:0] in_blue,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              word_tick,
    output logic              underflow,
    input  logic              clr_underflow,
    output logic [1:0]        out_clock,
    output logic [1:0]        out_red,
    output logic [1:0]        out_green,
    output logic [1:0]        out_blue
);

    localparam logic [3:0] LAST = last_slot(C_ddr);

    logic [3:0]        r_cnt;
    logic              r_hold_full;
    logic [TMDS_W-1:0] r_hold [3];
    logic              r_underflow;

    logic              w_boundary;
    logic              w_accept;
    logic [TMDS_W-1:0] w_in_word   [3];
    logic [TMDS_W-1:0] w_load_word [3];
    logic [1:0]        w_data_pair [3];

    assign w_boundary = (r_cnt == LAST);
    // A boundary drains the buffer, so it can be refilled in the same cycle.
    assign in_ready   = !r_hold_full | w_boundary;
    assign w_accept   = in_valid & in_ready;
    assign word_tick  = w_boundary;
    assign underflow  = r_underflow;

    assign w_in_word[0] = in_red;
    assign w_in_word[1] = in_green;
    assign w_in_word[2] = in_blue;

    always_ff @(posedge clk_shift) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_boundary) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_shift) begin
        if (rst) begin
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
        end else if (w_boundary) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_shift) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else if (w_boundary && !r_hold_full) begin
            r_underflow <= 1'b1;
        end else if (clr_underflow) begin
            r_underflow <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            always_ff @(posedge clk_shift) begin
                if (w_accept) begin
                    r_hold[gi] <= w_in_word[gi];
                end
            end

            // An empty buffer at the boundary sends the idle control symbol.
            assign w_load_word[gi] = r_hold_full ? r_hold[gi] : CTRL_00;

            tmds_shift_lane #(
                .C_ddr      (C_ddr),
                .P_RST_WORD (CTRL_00)
            ) u_lane (
                .clk_shift   (clk_shift),
                .rst         (rst),
                .i_load      (w_boundary),
                .i_load_word (w_load_word[gi]),
                .o_pair      (w_data_pair[gi])
            );
        end
    endgenerate

    tmds_shift_lane #(
        .C_ddr      (C_ddr),
        .P_RST_WORD (CLK_PAT)
    ) u_clk_lane (
        .clk_shift   (clk_shift),
        .rst         (rst),
        .i_load      (w_boundary),
        .i_load_word (CLK_PAT),
        .o_pair      (out_clock)
    );

    assign out_red   = w_data_pair[0];
    assign out_green = w_data_pair[1];
    assign out_blue  = w_data_pair[2];

endmodule

// File: tb/tb_tmds_serializer.sv
// -----------------------------------------------------------------------------
// tb_tmds_serializer
// Drives a DDR instance (index 0) and an SDR instance (index 1) with shared
// stimulus. A per-instance scoreboard queues accepted words and compares each
// completed word period; directed sequences cover the corner cases.
// -----------------------------------------------------------------------------
module tb_tmds_serializer;

    localparam logic [9:0] T_CTRL00 = 10'b1101010100;
    localparam logic [9:0] T_CLK    = 10'b0000011111;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } word3_t;

    typedef struct {
        logic [1:0] d_clk;
        logic [1:0] d_dat;
        logic       d_tick;
        logic       d_uf;
        logic [1:0] s_clk;
        logic [1:0] s_dat;
        logic       s_tick;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] in_red = '0, in_green = '0, in_blue = '0;
    logic       in_valid = 1'b0;
    logic       clr_underflow = 1'b0;

    logic [1:0] ob_clock [2];
    logic [1:0] ob_red   [2];
    logic [1:0] ob_green [2];
    logic [1:0] ob_blue  [2];
    logic       ob_ready [2];
    logic       ob_tick  [2];
    logic       ob_uf    [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tmds_serializer #(.C_ddr(1'b1)) u_ddr (
        .clk_shift(clk), .rst(rst),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_valid(in_valid), .in_ready(ob_ready[0]), .word_tick(ob_tick[0]),
        .underflow(ob_uf[0]), .clr_underflow(clr_underflow),
        .out_clock(ob_clock[0]), .out_red(ob_red[0]),
        .out_green(ob_green[0]), .out_blue(ob_blue[0])
    );

    tmds_serializer #(.C_ddr(1'b0)) u_sdr (
        .clk_shift(clk), .rst(rst),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .in_valid(in_valid), .in_ready(ob_ready[1]), .word_tick(ob_tick[1]),
        .underflow(ob_uf[1]), .clr_underflow(clr_underflow),
        .out_clock(ob_clock[1]), .out_red(ob_red[1]),
        .out_green(ob_green[1]), .out_blue(ob_blue[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slot-ordered 2-bit-per-slot image of a word as it should appear on a lane.
    function automatic logic [19:0] exp_raw(input logic [9:0] w, input bit ddr);
        logic [19:0] r;
        r = '0;
        if (ddr) begin
            r[9:0] = w;
        end else begin
            for (int k = 0; k < 10; k++) r[2*k] = w[k];
        end
        return r;
    endfunction

    // ---------------- scoreboard monitors ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mon
            localparam bit IS_DDR = (gi == 0);
            localparam int LASTM  = IS_DDR ? 4 : 9;
            word3_t      q [$];
            word3_t      cur;
            word3_t      nw;
            logic [19:0] a_r, a_g, a_b, a_c;
            int          pos;
            bit          exp_uf;
            bit          armed = 1'b0;
            bit          tick_e, rdy_e, empty_b;

            always @(negedge clk) begin
                if (rst) begin
                    q.delete();
                    cur    = {T_CTRL00, T_CTRL00, T_CTRL00};
                    pos    = 0;
                    exp_uf = 1'b0;
                    a_r = '0; a_g = '0; a_b = '0; a_c = '0;
                    armed  = 1'b1;
                end else if (armed) begin
                    tick_e  = (pos == LASTM);
                    empty_b = (q.size() == 0);
                    rdy_e   = empty_b || tick_e;
                    check(IS_DDR ? "ddr_tick" : "sdr_tick", 32'(ob_tick[gi]), 32'(tick_e));
                    check(IS_DDR ? "ddr_ready" : "sdr_ready", 32'(ob_ready[gi]), 32'(rdy_e));
                    check(IS_DDR ? "ddr_underflow" : "sdr_underflow", 32'(ob_uf[gi]), 32'(exp_uf));
                    a_r[2*pos +: 2] = ob_red[gi];
                    a_g[2*pos +: 2] = ob_green[gi];
                    a_b[2*pos +: 2] = ob_blue[gi];
                    a_c[2*pos +: 2] = ob_clock[gi];
                    if (tick_e) begin
                        $display("[%s] word red=%h green=%h blue=%h clock=%h",
                                 IS_DDR ? "DDR" : "SDR", a_r, a_g, a_b, a_c);
                        check(IS_DDR ? "ddr_red_word" : "sdr_red_word", 32'(a_r), 32'(exp_raw(cur.r, IS_DDR)));
                        check(IS_DDR ? "ddr_green_word" : "sdr_green_word", 32'(a_g), 32'(exp_raw(cur.g, IS_DDR)));
                        check(IS_DDR ? "ddr_blue_word" : "sdr_blue_word", 32'(a_b), 32'(exp_raw(cur.b, IS_DDR)));
                        check(IS_DDR ? "ddr_clock_word" : "sdr_clock_word", 32'(a_c), 32'(exp_raw(T_CLK, IS_DDR)));
                        a_r = '0; a_g = '0; a_b = '0; a_c = '0;
                        if (empty_b) cur = {T_CTRL00, T_CTRL00, T_CTRL00};
                        else         cur = q.pop_front();
                    end
                    if (tick_e && empty_b)  exp_uf = 1'b1;
                    else if (clr_underflow) exp_uf = 1'b0;
                    if (in_valid && rdy_e) begin
                        nw = {in_red, in_green, in_blue};
                        q.push_back(nw);
                    end
                    pos = tick_e ? 0 : pos + 1;
                end
            end
        end
    endgenerate

    // ---------------- stimulus helpers ----------------
    task automatic wait_tick(input int m, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (ob_tick[m]) seen = 1'b1;
        end
        check("tick_timeout", 32'(seen), 32'd1);
    endtask

    // Called at posedge+1; holds the word until instance m takes it, returns at posedge+1.
    task automatic send_word(input int m, input logic [9:0] r, input logic [9:0] g,
                             input logic [9:0] b, output bit acc_tick, output int waited);
        bit done;
        done = 1'b0; waited = 0; acc_tick = 1'b0;
        in_red = r; in_green = g; in_blue = b; in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ob_ready[m]) begin
                done = 1'b1;
                acc_tick = ob_tick[m];
            end else begin
                waited++;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    vec_t        tbl [10];
    bit          acc_tick;
    int          waited;
    logic [19:0] vec20, tick20;
    logic [9:0]  tick10, asm10;
    int          gap;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            d_clk  d_dat  dt  duf  s_clk  s_dat  st
        tbl[0] = '{2'b11, 2'b00, 0, 0, 2'b01, 2'b00, 0};
        tbl[1] = '{2'b11, 2'b01, 0, 0, 2'b01, 2'b00, 0};
        tbl[2] = '{2'b01, 2'b01, 0, 0, 2'b01, 2'b01, 0};
        tbl[3] = '{2'b00, 2'b01, 0, 0, 2'b01, 2'b00, 0};
        tbl[4] = '{2'b00, 2'b11, 1, 0, 2'b01, 2'b01, 0};
        tbl[5] = '{2'b11, 2'b00, 0, 1, 2'b00, 2'b00, 0};
        tbl[6] = '{2'b11, 2'b01, 0, 1, 2'b00, 2'b01, 0};
        tbl[7] = '{2'b01, 2'b01, 0, 1, 2'b00, 2'b00, 0};
        tbl[8] = '{2'b00, 2'b01, 0, 1, 2'b00, 2'b01, 0};
        tbl[9] = '{2'b00, 2'b11, 1, 1, 2'b00, 2'b01, 1};

        // Reset and idle output, both modes.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("tbl_ddr_clock", 32'(ob_clock[0]), 32'(tbl[i].d_clk));
            check("tbl_ddr_red",   32'(ob_red[0]),   32'(tbl[i].d_dat));
            check("tbl_ddr_blue",  32'(ob_blue[0]),  32'(tbl[i].d_dat));
            check("tbl_ddr_tick",  32'(ob_tick[0]),  32'(tbl[i].d_tick));
            check("tbl_ddr_uf",    32'(ob_uf[0]),    32'(tbl[i].d_uf));
            check("tbl_ddr_ready", 32'(ob_ready[0]), 32'd1);
            check("tbl_sdr_clock", 32'(ob_clock[1]), 32'(tbl[i].s_clk));
            check("tbl_sdr_green", 32'(ob_green[1]), 32'(tbl[i].s_dat));
            check("tbl_sdr_tick",  32'(ob_tick[1]),  32'(tbl[i].s_tick));
            check("tbl_sdr_uf",    32'(ob_uf[1]),    32'd0);
            $display("vec %0d: ddr clk=%b red=%b tick=%b | sdr clk=%b green=%b tick=%b",
                     i, ob_clock[0], ob_red[0], ob_tick[0], ob_clock[1], ob_green[1], ob_tick[1]);
        end
        @(posedge clk); #1;

        // DDR continuous stream of 10'h2AA on red.
        in_red = 10'h2AA; in_green = 10'h1F0; in_blue = 10'h33C; in_valid = 1'b1;
        wait_tick(0, 10);
        wait_tick(0, 10);
        @(posedge clk); #1;
        clr_underflow = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("stream_red", 32'(ob_red[0]), 32'h2);
            check("stream_ready", 32'(ob_ready[0]), 32'((k % 5) == 4));
            if (k >= 1) check("stream_uf", 32'(ob_uf[0]), 32'd0);
            @(posedge clk); #1;
            clr_underflow = 1'b0;
        end
        idle(12);

        // SDR back-to-back 3FF / 000 on green.
        send_word(1, 10'h000, 10'h3FF, 10'h000, acc_tick, waited);
        send_word(1, 10'h000, 10'h000, 10'h000, acc_tick, waited);
        in_valid = 1'b0;
        check("sdr_second_on_boundary", 32'(acc_tick), 32'd1);
        vec20 = '0; tick20 = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            vec20[k]  = ob_green[1][0];
            tick20[k] = ob_tick[1];
        end
        check("sdr_green_bits", 32'(vec20), 32'h003FF);
        check("sdr_tick_every_10", 32'(tick20), 32'h80200);
        gap = 0;
        wait_tick(1, 12);
        for (int k = 1; k <= 12 && gap == 0; k++) begin
            @(negedge clk);
            if (ob_tick[1]) gap = k;
        end
        check("sdr_tick_gap", 32'(gap), 32'd10);
        @(posedge clk); #1;
        idle(10);

        // DDR backpressure: hold full, 10'h155 waits for the boundary.
        wait_tick(0, 10);
        @(posedge clk); #1;
        send_word(0, 10'h0F0, 10'h0F0, 10'h0F0, acc_tick, waited);
        check("bp_first_wait", 32'(waited), 32'd0);
        send_word(0, 10'h155, 10'h155, 10'h155, acc_tick, waited);
        in_valid = 1'b0;
        check("bp_wait_cycles", 32'(waited), 32'd3);
        check("bp_taken_on_tick", 32'(acc_tick), 32'd1);
        repeat (5) @(negedge clk);
        asm10 = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            asm10[2*k +: 2] = ob_red[0];
        end
        check("bp_word_one_period_later", 32'(asm10), 32'h155);
        @(posedge clk); #1;
        idle(6);

        // DDR reset at cnt=2 with a word in flight and one held.
        in_red = 10'h3E0; in_green = 10'h3E0; in_blue = 10'h3E0; in_valid = 1'b1;
        wait_tick(0, 10);
        wait_tick(0, 10);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        vec20 = '0; tick10 = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("rst_ddr_clock", 32'(ob_clock[0]), 32'h3);
                check("rst_ddr_green", 32'(ob_green[0]), 32'h0);
                check("rst_ddr_ready", 32'(ob_ready[0]), 32'd1);
                check("rst_ddr_uf", 32'(ob_uf[0]), 32'd0);
                check("rst_sdr_clock", 32'(ob_clock[1]), 32'h1);
            end
            vec20[2*k +: 2] = ob_red[0];
            tick10[k] = ob_tick[0];
        end
        check("rst_tick_restart", 32'(tick10), 32'h210);
        check("rst_red_no_pending", 32'(vec20), 32'({T_CTRL00, T_CTRL00}));
        @(posedge clk); #1;
        idle(12);

        // Set beats clear on an underflowing boundary.
        clr_underflow = 1'b1;
        wait_tick(0, 10);
        @(negedge clk);
        check("uf_set_wins", 32'(ob_uf[0]), 32'd1);
        @(negedge clk);
        check("uf_clear_off_boundary", 32'(ob_uf[0]), 32'd0);
        @(posedge clk); #1;
        clr_underflow = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
